// File: rtl/regfile_wb.sv
// regfile_wb: register-file writeback arbiter with forwarding.
//
// Merges two writeback sources onto one registered regfile write port:
//   - the in-order pipeline (p_valid/p_waddr/p_wdata), which has no
//     backpressure other than p_stall;
//   - a long-latency unit (l_valid/l_ready/l_waddr/l_wdata), buffered in a
//     2-entry FIFO.
// The pipeline normally wins the port. A 2-bit starvation counter grows each
// cycle the pipeline wins while the FIFO holds something; at 3 the pipeline
// is stalled for one cycle so the FIFO head can drain.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   p_valid, p_waddr, p_wdata   pipeline result
//   p_stall                     pipeline must not present a result
//   l_valid, l_ready            long-latency handshake
//   l_waddr, l_wdata            long-latency result
//   we, waddr, wdata            registered regfile write port
//   raddr1, raddr2              decode read addresses
//   fwd_hit1/2, fwd_data1/2     combinational forwarding result
//   busy                        FIFO non-empty or write in flight
//
// Handshake: a long-latency transfer happens on a rising edge where l_valid
// and l_ready are both high; l_valid may not depend on l_ready, and l_ready
// depends only on registered occupancy and reset.

module regfile_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_waddr,
  input  logic [31:0] p_wdata,
  output logic        p_stall,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_waddr,
  input  logic [31:0] l_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        fwd_hit1,
  output logic [31:0] fwd_data1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data2,
  output logic        busy
);

  // FIFO kept as a shift structure: slot 0 is the head (oldest).
  logic [1:0]        count;
  logic [1:0]        ent_v;
  logic [1:0][4:0]   ent_a;
  logic [1:0][31:0]  ent_d;
  logic [1:0]        starve;

  logic [1:0]        n_count;
  logic [1:0]        n_v;
  logic [1:0][4:0]   n_a;
  logic [1:0][31:0]  n_d;
  logic [1:0]        n_starve;
  logic              n_we;
  logic [4:0]        n_waddr;
  logic [31:0]       n_wdata;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              p_acc;
  logic              kill;
  logic [1:0]        fill;
  logic              widx;

  always_comb begin
    empty   = (count == 2'd0);
    full    = (count == 2'd2);
    l_ready = !full && !reset;
    push    = l_valid && l_ready;
    p_stall = !reset && (starve == 2'd3) && !empty;
    p_acc   = !reset && p_valid && !p_stall;
    // The FIFO gets the port when stalling the pipeline or when it is idle.
    pop     = !reset && !empty && (p_stall || !p_valid);
    // A younger pipeline write supersedes buffered results to the same reg.
    kill    = p_acc && (p_waddr != 5'd0);
    busy    = !empty || we;
  end

  always_comb begin
    n_v     = ent_v;
    n_a     = ent_a;
    n_d     = ent_d;
    n_count = count + {1'b0, push} - {1'b0, pop};
    fill    = count - {1'b0, pop};
    widx    = fill[0];

    for (int i = 0; i < 2; i++) begin
      if (kill && (ent_a[i] == p_waddr)) n_v[i] = 1'b0;
    end

    if (pop) begin
      n_v[0] = n_v[1];
      n_a[0] = ent_a[1];
      n_d[0] = ent_d[1];
    end

    if (push) begin
      n_v[widx] = !(kill && (l_waddr == p_waddr));
      n_a[widx] = l_waddr;
      n_d[widx] = l_wdata;
    end
  end

  // Write-port selection. pop and p_acc are mutually exclusive, so the head
  // cannot be killed in the cycle it is popped.
  always_comb begin
    n_we    = 1'b0;
    n_waddr = waddr;
    n_wdata = wdata;
    if (pop) begin
      n_we    = ent_v[0] && (ent_a[0] != 5'd0);
      n_waddr = ent_a[0];
      n_wdata = ent_d[0];
    end else if (p_acc) begin
      n_we    = (p_waddr != 5'd0);
      n_waddr = p_waddr;
      n_wdata = p_wdata;
    end
  end

  always_comb begin
    n_starve = starve;
    if (pop) begin
      n_starve = 2'd0;
    end else if (!empty && p_acc && (starve != 2'd3)) begin
      n_starve = starve + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      ent_v  <= 2'b00;
      ent_a  <= '0;
      ent_d  <= '0;
      starve <= 2'd0;
      we     <= 1'b0;
      waddr  <= 5'd0;
      wdata  <= 32'd0;
    end else begin
      count  <= n_count;
      ent_v  <= n_v;
      ent_a  <= n_a;
      ent_d  <= n_d;
      starve <= n_starve;
      we     <= n_we;
      waddr  <= n_waddr;
      wdata  <= n_wdata;
    end
  end

  // Forwarding: pipeline this cycle, then write port, then FIFO youngest
  // first. Only occupied slots are considered.
  logic [1:0][4:0]  ra;
  logic [1:0]       hit;
  logic [1:0][31:0] fd;

  assign ra[0] = raddr1;
  assign ra[1] = raddr2;

  always_comb begin
    hit = 2'b00;
    fd  = '0;
    for (int k = 0; k < 2; k++) begin
      if (ra[k] != 5'd0) begin
        if (p_acc && (p_waddr == ra[k])) begin
          hit[k] = 1'b1;
          fd[k]  = p_wdata;
        end else if (we && (waddr == ra[k])) begin
          hit[k] = 1'b1;
          fd[k]  = wdata;
        end else if ((count == 2'd2) && ent_v[1] && (ent_a[1] == ra[k])) begin
          hit[k] = 1'b1;
          fd[k]  = ent_d[1];
        end else if ((count != 2'd0) && ent_v[0] && (ent_a[0] == ra[k])) begin
          hit[k] = 1'b1;
          fd[k]  = ent_d[0];
        end
      end
    end
  end

  assign fwd_hit1  = hit[0];
  assign fwd_data1 = fd[0];
  assign fwd_hit2  = hit[1];
  assign fwd_data2 = fd[1];

endmodule
